// File: rtl/issue_buff_ooo_pkg.sv
// Shared definitions for the out-of-order issue buffer.
//   - DEFAULT_FLAG_COUNT : default width of the completion-flag / dependency mask
//   - count_w(n)         : width of a port that counts 0..n (e.g. din_valid_ct, occupancy)
//   - index_w(n)         : width of a binary index into n entries (at least 1)
//   - deps_lsb / valid_bit : field offsets of the packed entry {valid, deps, payload}
package issue_pkg;

   localparam int DEFAULT_FLAG_COUNT = 10;

   function automatic int count_w(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic int index_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Entry layout, LSB first: payload [dw-1:0], deps [dw +: fc], valid [dw+fc]
   function automatic int deps_lsb(input int dw);
      return dw;
   endfunction

   function automatic int valid_bit(input int dw, input int fc);
      return dw + fc;
   endfunction

endpackage

// File: rtl/issue_buff_ooo_pick.sv
// oldest_ready_pick: fixed-priority picker, lowest index wins.
// Ports:
//   i_req   in  N             request vector (bit 0 = oldest entry)
//   o_grant out N             one-hot grant of the lowest set request bit
//   o_idx   out index_w(N)    binary index of the granted bit (0 when none)
//   o_any   out 1             at least one request is set
module oldest_ready_pick
   import issue_pkg::*;
#(
   parameter int N = 8
)(
   input  logic [N-1:0]            i_req,
   output logic [N-1:0]            o_grant,
   output logic [index_w(N)-1:0]   o_idx,
   output logic                    o_any
);

   localparam int IW = index_w(N);

   always_comb begin
      o_idx = '0;
      // Scan from the top so the last hit is the lowest index.
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx = IW'(i);
         end
      end
      // Isolate the lowest set bit.
      o_grant = i_req & (~i_req + N'(1));
      o_any   = |i_req;
   end

endmodule

// File: rtl/issue_buff_ooo.sv
// issue_buff_ooo: age-ordered collapsing issue queue with dependency wakeup.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   din            PUSH_WIDTH payloads, slot 0 in the LSBs is the oldest
//   din_deps       per-slot dependency masks, same slot order
//   din_valid_ct   number of valid slots counted from slot 0
//   din_ready_ct   number of slots that will be accepted this cycle
//   dout           payload of the selected uop (0 when none selected)
//   dout_valid     a selected uop exists
//   dout_ready     execution port accepts dout
//   done_flags     level completion flags; set bit satisfies a dependency
//   flush          discard every entry at the next edge
//   occupancy      entries currently held
module issue_buff_ooo
   import issue_pkg::*;
#(
   parameter int DATA_WIDTH = 47,
   parameter int PUSH_WIDTH = 4,
   parameter int ELEMENTS   = 8,
   parameter int FLAG_COUNT = DEFAULT_FLAG_COUNT,
   parameter int IN_ORDER   = 0
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic [DATA_WIDTH*PUSH_WIDTH-1:0]   din,
   input  logic [FLAG_COUNT*PUSH_WIDTH-1:0]   din_deps,
   input  logic [count_w(PUSH_WIDTH)-1:0]     din_valid_ct,
   output logic [count_w(PUSH_WIDTH)-1:0]     din_ready_ct,
   output logic [DATA_WIDTH-1:0]              dout,
   output logic                               dout_valid,
   input  logic                               dout_ready,
   input  logic [FLAG_COUNT-1:0]              done_flags,
   input  logic                               flush,
   output logic [count_w(ELEMENTS)-1:0]       occupancy
);

   localparam int PCW = count_w(PUSH_WIDTH);
   localparam int OCW = count_w(ELEMENTS);
   localparam int IW  = index_w(ELEMENTS);
   localparam int DL  = deps_lsb(DATA_WIDTH);
   localparam int VB  = valid_bit(DATA_WIDTH, FLAG_COUNT);
   localparam int EW  = VB + 1;

   logic [EW-1:0]       w_entry [ELEMENTS];
   logic [OCW-1:0]      r_count;
   logic [ELEMENTS-1:0] w_ready;
   logic [ELEMENTS-1:0] w_req;
   logic [ELEMENTS-1:0] w_grant;
   logic [IW-1:0]       w_sel;
   logic                w_any;
   logic                w_pop;
   logic [OCW-1:0]      w_free;
   logic [OCW-1:0]      w_ready_ct;
   logic [OCW-1:0]      w_valid_ct;
   logic [OCW-1:0]      w_acc;
   logic [OCW-1:0]      w_base;
   logic [OCW-1:0]      w_count_next;

   // ---------------- selection ----------------
   // In-order mode only ever offers the head entry to the picker.
   assign w_req = (IN_ORDER != 0) ? (w_ready & ELEMENTS'(1)) : w_ready;

   oldest_ready_pick #(.N(ELEMENTS)) u_pick (
      .i_req   (w_req),
      .o_grant (w_grant),
      .o_idx   (w_sel),
      .o_any   (w_any)
   );

   always_comb begin
      dout = '0;
      for (int i = 0; i < ELEMENTS; i++) begin
         if (w_grant[i]) begin
            dout = dout | w_entry[i][DATA_WIDTH-1:0];
         end
      end
   end

   assign dout_valid = w_any;
   assign w_pop      = w_any && dout_ready;

   // ---------------- counts ----------------
   // Ready count depends only on registered occupancy, so a pop this cycle
   // does not raise it until the next cycle.
   assign w_free       = OCW'(ELEMENTS) - r_count;
   assign w_ready_ct   = (w_free > OCW'(PUSH_WIDTH)) ? OCW'(PUSH_WIDTH) : w_free;
   assign din_ready_ct = PCW'(w_ready_ct);
   assign w_valid_ct   = OCW'(din_valid_ct);
   assign w_acc        = (w_valid_ct < w_ready_ct) ? w_valid_ct : w_ready_ct;
   assign w_base       = r_count - OCW'(w_pop);
   assign w_count_next = flush ? '0 : (w_base + w_acc);
   assign occupancy    = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   // ---------------- per-entry storage ----------------
   genvar gi;
   generate
      for (gi = 0; gi < ELEMENTS; gi++) begin : g_ent
         localparam logic [OCW-1:0] IDX = OCW'(gi);
         logic [EW-1:0] r_entry;
         logic [EW-1:0] w_next;
         logic [EW-1:0] w_above;

         if (gi < ELEMENTS - 1) begin : g_up
            assign w_above = w_entry[gi+1];
         end else begin : g_top
            assign w_above = '0;
         end

         assign w_entry[gi] = r_entry;
         assign w_ready[gi] = r_entry[VB] &&
                              ((r_entry[DL +: FLAG_COUNT] & ~done_flags) == '0);

         always_comb begin
            w_next = r_entry;
            // Compaction: the popped slot and everything above it take the
            // entry from one index higher, preserving age order.
            if (w_pop && (IDX >= OCW'(w_sel))) begin
               w_next = w_above;
            end
            // Push lands just past the post-pop occupancy.
            for (int k = 0; k < PUSH_WIDTH; k++) begin
               if ((OCW'(k) < w_acc) && (IDX == w_base + OCW'(k))) begin
                  w_next[DATA_WIDTH-1:0]   = din[k*DATA_WIDTH +: DATA_WIDTH];
                  w_next[DL +: FLAG_COUNT] = din_deps[k*FLAG_COUNT +: FLAG_COUNT];
               end
            end
            // Valid bits stay contiguous from index 0.
            w_next[VB] = !flush && (IDX < w_count_next);
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_entry <= '0;
            end else begin
               r_entry <= w_next;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_issue_buff_ooo.sv
module tb_issue_buff_ooo;

   localparam int DW  = 47;
   localparam int PW  = 4;
   localparam int EL  = 8;
   localparam int FC  = 10;
   localparam int PCW = 3;
   localparam int OCW = 4;
   localparam int NV  = 35;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // out-of-order instance
   logic [DW*PW-1:0] din0;
   logic [FC*PW-1:0] deps0;
   logic [PCW-1:0]   vct0, rct0;
   logic [DW-1:0]    dout0;
   logic             dv0, rdy0, flush0;
   logic [FC-1:0]    flags0;
   logic [OCW-1:0]   occ0;

   // in-order instance
   logic [DW*PW-1:0] din1;
   logic [FC*PW-1:0] deps1;
   logic [PCW-1:0]   vct1, rct1;
   logic [DW-1:0]    dout1;
   logic             dv1, rdy1, flush1;
   logic [FC-1:0]    flags1;
   logic [OCW-1:0]   occ1;

   issue_buff_ooo #(.DATA_WIDTH(DW), .PUSH_WIDTH(PW), .ELEMENTS(EL), .FLAG_COUNT(FC), .IN_ORDER(0)) u_dut0 (
      .clk(clk), .rst(rst), .din(din0), .din_deps(deps0), .din_valid_ct(vct0),
      .din_ready_ct(rct0), .dout(dout0), .dout_valid(dv0), .dout_ready(rdy0),
      .done_flags(flags0), .flush(flush0), .occupancy(occ0));

   issue_buff_ooo #(.DATA_WIDTH(DW), .PUSH_WIDTH(PW), .ELEMENTS(EL), .FLAG_COUNT(FC), .IN_ORDER(1)) u_dut1 (
      .clk(clk), .rst(rst), .din(din1), .din_deps(deps1), .din_valid_ct(vct1),
      .din_ready_ct(rct1), .dout(dout1), .dout_valid(dv1), .dout_ready(rdy1),
      .done_flags(flags1), .flush(flush1), .occupancy(occ1));

   typedef struct {
      logic [2:0]  vct;
      logic [46:0] pid;      // slot k payload = pid + k
      logic [9:0]  dp0, dp1, dp2, dp3;
      logic        rdy;
      logic [9:0]  flags;
      logic        flush;
      logic [3:0]  e_occ;
      logic        e_dv;
      logic [46:0] e_dout;
      logic [2:0]  e_rct;
   } vec_t;

   vec_t tbl [NV];
   int   checks = 0;
   int   errors = 0;
   string ctx = "";

   function automatic vec_t mk(int vct, int pid, int dp0, int dp1, int dp2, int dp3,
                               int rdy, int flags, int fl,
                               int e_occ, int e_dv, int e_dout, int e_rct);
      vec_t v;
      v.vct = 3'(vct);     v.pid = 47'(pid);
      v.dp0 = 10'(dp0);    v.dp1 = 10'(dp1);  v.dp2 = 10'(dp2);  v.dp3 = 10'(dp3);
      v.rdy = 1'(rdy);     v.flags = 10'(flags); v.flush = 1'(fl);
      v.e_occ = 4'(e_occ); v.e_dv = 1'(e_dv); v.e_dout = 47'(e_dout); v.e_rct = 3'(e_rct);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %0h expected %0h", ctx, nm, act, exp);
      end
   endtask

   task automatic drive0(input vec_t v);
      for (int k = 0; k < PW; k++) din0[k*DW +: DW] = v.pid + 47'(k);
      deps0  = {v.dp3, v.dp2, v.dp1, v.dp0};
      vct0   = v.vct;
      rdy0   = v.rdy;
      flags0 = v.flags;
      flush0 = v.flush;
   endtask

   initial begin
      din0 = '0; deps0 = '0; vct0 = '0; rdy0 = 1'b0; flags0 = '0; flush0 = 1'b0;
      din1 = '0; deps1 = '0; vct1 = '0; rdy1 = 1'b0; flags1 = '0; flush1 = 1'b0;

      //                 vct pid   dp0 dp1 dp2 dp3 rdy flags  fl  occ dv dout  rct
      tbl[0]  = mk(0, 0,     0, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);
      tbl[1]  = mk(3, 'h10,  0, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);
      tbl[2]  = mk(0, 0,     0, 0, 0, 0, 0, 0,     0,  3, 1, 'h10,  4);
      tbl[3]  = mk(0, 0,     0, 0, 0, 0, 1, 0,     0,  3, 1, 'h10,  4);
      tbl[4]  = mk(0, 0,     0, 0, 0, 0, 1, 0,     0,  2, 1, 'h11,  4);
      tbl[5]  = mk(0, 0,     0, 0, 0, 0, 1, 0,     0,  1, 1, 'h12,  4);
      tbl[6]  = mk(0, 0,     0, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);
      tbl[7]  = mk(2, 'h20,  1, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);
      tbl[8]  = mk(0, 0,     0, 0, 0, 0, 1, 0,     0,  2, 1, 'h21,  4);
      tbl[9]  = mk(0, 0,     0, 0, 0, 0, 1, 0,     0,  1, 0, 0,     4);
      tbl[10] = mk(0, 0,     0, 0, 0, 0, 1, 1,     0,  1, 1, 'h20,  4);
      tbl[11] = mk(0, 0,     0, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);
      tbl[12] = mk(1, 'h30,  2, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);
      tbl[13] = mk(0, 0,     0, 0, 0, 0, 0, 2,     0,  1, 1, 'h30,  4);
      tbl[14] = mk(0, 0,     0, 0, 0, 0, 1, 0,     0,  1, 0, 0,     4);
      tbl[15] = mk(0, 0,     0, 0, 0, 0, 1, 'h3FF, 0,  1, 1, 'h30,  4);
      tbl[16] = mk(0, 0,     0, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);
      tbl[17] = mk(4, 'h40,  0, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);
      tbl[18] = mk(4, 'h44,  0, 0, 0, 0, 0, 0,     0,  4, 1, 'h40,  4);
      tbl[19] = mk(4, 'h50,  0, 0, 0, 0, 0, 0,     0,  8, 1, 'h40,  0);
      tbl[20] = mk(0, 0,     0, 0, 0, 0, 1, 0,     0,  8, 1, 'h40,  0);
      tbl[21] = mk(4, 'h60,  0, 0, 0, 0, 0, 0,     0,  7, 1, 'h41,  1);
      tbl[22] = mk(2, 'h70,  0, 0, 0, 0, 1, 0,     1,  8, 1, 'h41,  0);
      tbl[23] = mk(0, 0,     0, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);
      tbl[24] = mk(4, 'h80,  1, 1, 0, 1, 0, 0,     0,  0, 0, 0,     4);
      tbl[25] = mk(1, 'h84,  1, 0, 0, 0, 0, 0,     0,  4, 1, 'h82,  4);
      tbl[26] = mk(2, 'h90,  1, 1, 0, 0, 1, 0,     0,  5, 1, 'h82,  3);
      tbl[27] = mk(0, 0,     0, 0, 0, 0, 0, 1,     0,  6, 1, 'h80,  2);
      tbl[28] = mk(0, 0,     0, 0, 0, 0, 1, 'h3FF, 0,  6, 1, 'h80,  2);
      tbl[29] = mk(0, 0,     0, 0, 0, 0, 1, 'h3FF, 0,  5, 1, 'h81,  3);
      tbl[30] = mk(0, 0,     0, 0, 0, 0, 1, 'h3FF, 0,  4, 1, 'h83,  4);
      tbl[31] = mk(0, 0,     0, 0, 0, 0, 1, 'h3FF, 0,  3, 1, 'h84,  4);
      tbl[32] = mk(0, 0,     0, 0, 0, 0, 1, 'h3FF, 0,  2, 1, 'h90,  4);
      tbl[33] = mk(0, 0,     0, 0, 0, 0, 1, 'h3FF, 0,  1, 1, 'h91,  4);
      tbl[34] = mk(0, 0,     0, 0, 0, 0, 0, 0,     0,  0, 0, 0,     4);

      repeat (2) @(negedge clk);
      rst = 1'b0;

      // ---- table: out-of-order instance, one row per cycle ----
      for (int r = 0; r < NV; r++) begin
         @(negedge clk);
         drive0(tbl[r]);
         #1;
         ctx = $sformatf("row%0d", r);
         $display("row %0d: vct=%0d rdy=%0d flags=%h flush=%0d -> occ=%0d dv=%0d dout=%h rct=%0d",
                  r, tbl[r].vct, tbl[r].rdy, tbl[r].flags, tbl[r].flush, occ0, dv0, dout0, rct0);
         chk("occupancy",    64'(occ0),  64'(tbl[r].e_occ));
         chk("dout_valid",   64'(dv0),   64'(tbl[r].e_dv));
         chk("dout",         64'(dout0), 64'(tbl[r].e_dout));
         chk("din_ready_ct", 64'(rct0),  64'(tbl[r].e_rct));
      end
      @(negedge clk);
      drive0(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // ---- in-order instance: head-only issue ----
      ctx = "inorder";
      vct1 = 3'd2; din1[0 +: DW] = 47'h20; din1[DW +: DW] = 47'h21;
      deps1 = {10'h0, 10'h0, 10'h0, 10'h001};
      #1; chk("io_occ_pre", 64'(occ1), 64'd0);
      $display("inorder push 2 (0x20 deps=1, 0x21 deps=0)");
      @(negedge clk); vct1 = '0; rdy1 = 1'b1;
      #1; chk("io_occ", 64'(occ1), 64'd2); chk("io_dv_blocked1", 64'(dv1), 64'd0);
      $display("inorder flags=0 occ=%0d dv=%0d", occ1, dv1);
      @(negedge clk);
      #1; chk("io_dv_blocked2", 64'(dv1), 64'd0); chk("io_occ_hold", 64'(occ1), 64'd2);
      $display("inorder flags=0 occ=%0d dv=%0d", occ1, dv1);
      @(negedge clk); flags1 = 10'h001;
      #1; chk("io_dv_head", 64'(dv1), 64'd1); chk("io_dout_head", 64'(dout1), 64'h20);
      $display("inorder flags=1 dv=%0d dout=%h", dv1, dout1);
      @(negedge clk);
      #1; chk("io_dout_second", 64'(dout1), 64'h21); chk("io_occ1", 64'(occ1), 64'd1);
      $display("inorder pop dv=%0d dout=%h occ=%0d", dv1, dout1, occ1);
      @(negedge clk); rdy1 = 1'b0;
      #1; chk("io_empty_dv", 64'(dv1), 64'd0); chk("io_empty_occ", 64'(occ1), 64'd0);
      $display("inorder drained occ=%0d dv=%0d", occ1, dv1);

      // ---- asynchronous reset mid-stream ----
      ctx = "async_rst";
      @(negedge clk);
      drive0(mk(2, 'hA0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      vct0 = '0;
      #1; chk("pre_rst_occ", 64'(occ0), 64'd2); chk("pre_rst_dv", 64'(dv0), 64'd1);
      #2 rst = 1'b1;
      #1;  // still before the next rising edge
      chk("rst_occ",  64'(occ0),  64'd0);
      chk("rst_dv",   64'(dv0),   64'd0);
      chk("rst_dout", 64'(dout0), 64'd0);
      chk("rst_rct",  64'(rct0),  64'd4);
      $display("async rst: occ=%0d dv=%0d dout=%h rct=%0d", occ0, dv0, dout0, rct0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      #1; chk("post_rst_occ", 64'(occ0), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
